// File: rtl/video_timing_gen.sv
// Raster timing generator: blanking, active-low syncs, beam counters and a centred window.
// Optional interlace (field 1 one line longer, half-line vsync) is enabled by defining INTERLACE_EN.
module video_timing_gen #(
  parameter int CW       = 9,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 18,
  parameter int H_SYNC   = 25,
  parameter int H_TOTAL  = 443,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 18,
  parameter int V_SYNC   = 3,
  parameter int V_TOTAL  = 263,
  parameter int WIN_X0   = 32,
  parameter int WIN_Y0   = 20,
  parameter int WIN_W    = 192,
  parameter int WIN_H    = 184
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          interlace,
  output logic          hs,
  output logic          vs,
  output logic          hb,
  output logic          vb,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          win_de,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          field
);

  localparam logic [CW-1:0] LP_H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] LP_V_LAST0 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] LP_V_LAST1 = CW'(V_TOTAL);
  localparam logic [CW-1:0] LP_HA      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] LP_HS0     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] LP_HS1     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] LP_VA      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] LP_VS0     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] LP_VS1     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] LP_WX0     = CW'(WIN_X0);
  localparam logic [CW-1:0] LP_WX1     = CW'(WIN_X0 + WIN_W);
  localparam logic [CW-1:0] LP_WY0     = CW'(WIN_Y0);
  localparam logic [CW-1:0] LP_WY1     = CW'(WIN_Y0 + WIN_H);
`ifdef INTERLACE_EN
  localparam logic [CW-1:0] LP_H_HALF  = CW'(H_TOTAL / 2);
`endif

  logic [CW-1:0] r_hcount, r_vcount, r_win_x, r_win_y;
  logic          r_hs, r_vs, r_hb, r_vb, r_win_de, r_field;

  logic [CW-1:0] w_h_nxt, w_v_nxt, w_win_x_nxt, w_win_y_nxt;
  logic          w_h_wrap, w_v_last, w_field_nxt;
  logic          w_hs_nxt, w_vs_nxt, w_hb_nxt, w_vb_nxt, w_win_de_nxt;

  function automatic logic f_in_range(input logic [CW-1:0] val,
                                      input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

  // Next beam position; decoding the next position keeps outputs aligned with the counters.
  always_comb begin
    w_h_wrap = (r_hcount == LP_H_LAST);
    w_v_last = (r_vcount == (r_field ? LP_V_LAST1 : LP_V_LAST0));
    w_h_nxt  = w_h_wrap ? '0 : r_hcount + CW'(1);
    w_v_nxt  = r_vcount;
    if (w_h_wrap) w_v_nxt = w_v_last ? '0 : r_vcount + CW'(1);
`ifdef INTERLACE_EN
    w_field_nxt = r_field;
    if (w_h_wrap && w_v_last) w_field_nxt = interlace ? ~r_field : 1'b0;
`else
    w_field_nxt = 1'b0;
`endif
  end

  always_comb begin
    w_hb_nxt     = (w_h_nxt >= LP_HA);
    w_vb_nxt     = (w_v_nxt >= LP_VA);
    w_hs_nxt     = ~f_in_range(w_h_nxt, LP_HS0, LP_HS1);
    w_vs_nxt     = ~f_in_range(w_v_nxt, LP_VS0, LP_VS1);
`ifdef INTERLACE_EN
    // Field 1 shifts both vsync edges to mid-line.
    if (w_field_nxt)
      w_vs_nxt = ~(((w_v_nxt == LP_VS0) && (w_h_nxt >= LP_H_HALF)) ||
                   ((w_v_nxt > LP_VS0) && (w_v_nxt < LP_VS1)) ||
                   ((w_v_nxt == LP_VS1) && (w_h_nxt < LP_H_HALF)));
`endif
    w_win_de_nxt = f_in_range(w_h_nxt, LP_WX0, LP_WX1) && f_in_range(w_v_nxt, LP_WY0, LP_WY1);
    w_win_x_nxt  = w_win_de_nxt ? (w_h_nxt - LP_WX0) : '0;
    w_win_y_nxt  = w_win_de_nxt ? (w_v_nxt - LP_WY0) : '0;
  end

`ifndef INTERLACE_EN
  logic w_unused_interlace;
  assign w_unused_interlace = interlace;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_hb     <= 1'b0;
      r_vb     <= 1'b0;
      r_win_de <= 1'b0;
      r_win_x  <= '0;
      r_win_y  <= '0;
      r_field  <= 1'b0;
    end else if (ce) begin
      r_hcount <= w_h_nxt;
      r_vcount <= w_v_nxt;
      r_hs     <= w_hs_nxt;
      r_vs     <= w_vs_nxt;
      r_hb     <= w_hb_nxt;
      r_vb     <= w_vb_nxt;
      r_win_de <= w_win_de_nxt;
      r_win_x  <= w_win_x_nxt;
      r_win_y  <= w_win_y_nxt;
      r_field  <= w_field_nxt;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign hb          = r_hb;
  assign vb          = r_vb;
  assign win_de      = r_win_de;
  assign win_x       = r_win_x;
  assign win_y       = r_win_y;
  assign field       = r_field;
  assign line_start  = (r_hcount == '0);
  assign frame_start = (r_hcount == '0) && (r_vcount == '0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (H_ACTIVE + H_FP + H_SYNC <= H_TOTAL) else $error("horizontal timing exceeds H_TOTAL");
    assert (V_ACTIVE + V_FP + V_SYNC <= V_TOTAL) else $error("vertical timing exceeds V_TOTAL");
    assert ((WIN_X0 + WIN_W <= H_ACTIVE) && (WIN_Y0 + WIN_H <= V_ACTIVE))
      else $error("window outside active area");
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen; vertical timing shortened so whole frames fit the run.
module tb_video_timing_gen;
  localparam int CW  = 9;
  localparam int HT  = 443, HA = 256, HFP = 18, HSY = 25;
  localparam int VT  = 50,  VA = 40,  VFP = 4,  VSY = 3;
  localparam int WX0 = 32,  WY0 = 8,  WW = 192, WH = 24;

  logic clk, reset, ce, interlace;
  logic hs, vs, hb, vb, win_de, line_start, frame_start, field;
  logic [CW-1:0] hcount, vcount, win_x, win_y;
  int vectors = 0;
  int errs = 0;

  video_timing_gen #(
    .CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_TOTAL(VT),
    .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .interlace(interlace),
    .hs(hs), .vs(vs), .hb(hb), .vb(vb), .hcount(hcount), .vcount(vcount),
    .win_de(win_de), .win_x(win_x), .win_y(win_y),
    .line_start(line_start), .frame_start(frame_start), .field(field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && n < 60000) begin
      step();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", h, v), int'(int'(hcount) == h && int'(vcount) == v), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; ce = 1'b0; interlace = 1'b0;
    #12;
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_hb", hb, 0);
    chk("rst_vb", vb, 0);
    chk("rst_win_de", win_de, 0);
    chk("rst_win_x", win_x, 0);
    chk("rst_win_y", win_y, 0);
    chk("rst_field", field, 0);
    chk("rst_line_start", line_start, 1);
    chk("rst_frame_start", frame_start, 1);

    reset = 1'b0; ce = 1'b1;
    step();
    chk("first_hcount", hcount, 1);
    chk("first_line_start", line_start, 0);
    chk("first_frame_start", frame_start, 0);

    goto(HA - 1, 0);   chk("hb_255", hb, 0);
    step();            chk("hb_256", hb, 1);
    goto(273, 0);      chk("hs_273", hs, 1);
    step();            chk("hs_274", hs, 0);
    goto(298, 0);      chk("hs_298", hs, 0);
    step();            chk("hs_299", hs, 1);
    goto(HT - 1, 0);
    step();
    chk("hwrap_hcount", hcount, 0);
    chk("hwrap_vcount", vcount, 1);
    chk("hwrap_line_start", line_start, 1);
    chk("hwrap_frame_start", frame_start, 0);
    chk("hwrap_hb", hb, 0);

    goto(WX0 - 1, WY0); chk("win_before", win_de, 0);
    step();
    chk("win_first_de", win_de, 1);
    chk("win_first_x", win_x, 0);
    chk("win_first_y", win_y, 0);
    goto(WX0 + WW - 1, WY0 + WH - 1);
    chk("win_last_de", win_de, 1);
    chk("win_last_x", win_x, WW - 1);
    chk("win_last_y", win_y, WH - 1);
    step();
    chk("win_after_de", win_de, 0);
    chk("win_after_x", win_x, 0);

    goto(0, VA - 1);   chk("vb_39", vb, 0);
    goto(0, VA);       chk("vb_40", vb, 1);
    goto(HT - 1, VA + VFP - 1); chk("vs_43", vs, 1);
    step();            chk("vs_44", vs, 0);
    goto(HT - 1, VA + VFP + VSY - 1); chk("vs_46", vs, 0);
    step();            chk("vs_47", vs, 1);

    goto(HT - 1, VT - 1);
    step();
    chk("fwrap_hcount", hcount, 0);
    chk("fwrap_vcount", vcount, 0);
    chk("fwrap_frame_start", frame_start, 1);
    chk("fwrap_vb", vb, 0);
    chk("fwrap_vs", vs, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 30000);
    chk("frame_period", n, HT * VT);

    ce = 1'b0; step();
    chk("ce0_hcount", hcount, 0);
    chk("ce0_line_start", line_start, 1);
    ce = 1'b1; step();
    chk("ce1_hcount", hcount, 1);
    chk("ce1_line_start", line_start, 0);
    ce = 1'b0; step();
    chk("ce0b_hcount", hcount, 1);
    ce = 1'b1;

    goto(300, 20);
    chk("pre_rst_hb", hb, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hcount", hcount, 0);
    chk("async_rst_vcount", vcount, 0);
    chk("async_rst_hb", hb, 0);
    chk("async_rst_hs", hs, 1);
    chk("async_rst_win_de", win_de, 0);
    step();
    chk("held_rst_hcount", hcount, 0);
    reset = 1'b0;
    step();
    chk("post_rst_hcount", hcount, 1);

    interlace = 1'b1;
    goto(HT - 1, VT - 1);
    step();
`ifdef INTERLACE_EN
    chk("il_field1", field, 1);
    chk("il_frame_start", frame_start, 1);
    goto(HT / 2 - 1, VA + VFP); chk("il_vs_before_half", vs, 1);
    step();                      chk("il_vs_fall_half", vs, 0);
    goto(HT / 2 - 1, VA + VFP + VSY); chk("il_vs_hold", vs, 0);
    step();                      chk("il_vs_rise_half", vs, 1);
    goto(HT - 1, VT - 1);
    step();
    chk("il_extra_line", vcount, VT);
    chk("il_extra_field", field, 1);
    goto(HT - 1, VT);
    step();
    chk("il_wrap_vcount", vcount, 0);
    chk("il_field0", field, 0);
`else
    chk("nil_vcount", vcount, 0);
    chk("nil_field", field, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator producing blanking, active-low syncs, raw beam counters and a centred inner display window with window-relative coordinates. It sits between the pixel clock domain and the VDP/framebuffer fetch logic. Defaults give NTSC-style 256x224 active timing with a 192x184 system window centred inside it. A pixel clock enable lets one fast clock drive it, and an optional interlace mode is available.

## Interface
Parameters:
- CW, 9, counter/coordinate width; must hold max(H_TOTAL-1, V_TOTAL).
- H_ACTIVE, 256, visible pixels per line.
- H_FP, 18, front porch pixels.
- H_SYNC, 25, hsync pixels.
- H_TOTAL, 443, pixels per line.
- V_ACTIVE, 224, visible lines.
- V_FP, 18, front porch lines.
- V_SYNC, 3, vsync lines.
- V_TOTAL, 263, lines per frame (progressive / even field).
- WIN_X0, 32, window first column (hcount).
- WIN_Y0, 20, window first line (vcount).
- WIN_W, 192, window width.
- WIN_H, 184, window height.

Ports:
- clk, in, 1: clock; one clock domain only.
- reset, in, 1: asynchronous, active-high.
- ce, in, 1: pixel enable; counters advance only when ce=1.
- interlace, in, 1: interlace request; ignored unless INTERLACE_EN is defined.
- hs, out, 1: horizontal sync, active low.
- vs, out, 1: vertical sync, active low.
- hb, out, 1: horizontal blank.
- vb, out, 1: vertical blank.
- hcount, out, CW: pixel within the line.
- vcount, out, CW: line within the frame.
- win_de, out, 1: beam is inside the window.
- win_x, out, CW: window-relative column.
- win_y, out, CW: window-relative line.
- line_start, out, 1: high while hcount==0.
- frame_start, out, 1: high while hcount==0 and vcount==0.
- field, out, 1: current interlace field.

## Operation
- Reset values: hcount=0, vcount=0, hs=1, vs=1, hb=0, vb=0, win_de=0, win_x=0, win_y=0, field=0. The strobes follow from the counters, so line_start=1 and frame_start=1 during reset.
- On a clk edge with ce=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - At the last line of the frame, vcount wraps to 0.
- With ce=0, every register holds.
- Outputs are registered and always consistent with the current hcount/vcount:
  - hb=1 iff hcount >= H_ACTIVE.
  - hs=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vb=1 iff vcount >= V_ACTIVE.
  - vs=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (progressive case).
  - win_de=1 iff WIN_X0 <= hcount < WIN_X0+WIN_W and WIN_Y0 <= vcount < WIN_Y0+WIN_H.
  - win_x = hcount-WIN_X0 and win_y = vcount-WIN_Y0 when win_de=1; both are 0 otherwise.
- Required parameter constraints, checked by simulation-only assertion:
  - H_ACTIVE+H_FP+H_SYNC <= H_TOTAL.
  - V_ACTIVE+V_FP+V_SYNC <= V_TOTAL.
  - The window lies inside the active area.
- All arithmetic is unsigned CW-bit; no overflow is possible given the constraints.

## Timing
- Line period is H_TOTAL ce-cycles; frame period is H_TOTAL*V_TOTAL ce-cycles (116509 by default).
- Zero latency between a counter value and its decoded outputs: they update on the same edge.
- line_start/frame_start last one pixel period, i.e. every clk cycle until the next ce.
- Asserting reset mid-line forces the reset values immediately, without waiting for a clock edge.
- After reset deasserts, the first ce=1 edge gives hcount=1.
- Simultaneous hcount and vcount wrap on one edge yields hcount=0, vcount=0, and frame_start goes high.

## Configuration
- INTERLACE_EN defined:
  - interlace is sampled only on the edge entering hcount=0, vcount=0.
  - When the sample is 1, field toggles at each frame wrap. Field 1 is V_TOTAL+1 lines long.
  - In field 1, vs falls and rises at hcount=H_TOTAL/2 (integer division) of lines V_ACTIVE+V_FP and V_ACTIVE+V_FP+V_SYNC, instead of at hcount=0.
  - When the sample is 0, field=0 and timing is progressive.
- INTERLACE_EN undefined: the interlace port is ignored, field is tied to 0, and timing is strictly progressive.

## Test plan
- Defaults, ce=1, run two frames -> hcount wraps 442->0; vcount wraps 262->0; frame_start recurs every 116509 clocks.
- Line decode -> hb rises at hcount=256; hs is low for hcount 274..298 (25 clocks).
- Frame decode -> vb is high for lines 224..262; vs is low for lines 242..244.
- Window -> win_de is first high at hcount=32, vcount=20 with win_x=0, win_y=0; last high at hcount=223, vcount=203 with win_x=191, win_y=183.
- ce toggled 1,0,1,0 -> counters advance every other clock, and line_start stays high for 2 clocks.
- Reset asserted at hcount=300, vcount=100 -> all outputs return to reset values immediately. With INTERLACE_EN and interlace=1: field alternates, field 1 has 264 lines, and vs falls at hcount=221 of line 242.
